// File: rtl/ddr_word_reader_if.sv
// Request/response bundle between the GPU read port, ddr_word_reader and the DDR arbiter.
// slave: the word reader itself; master: the surrounding GPU port and DDR side.
interface ddr_word_reader_if;
  logic        enable;
  logic        invalidate;
  logic        in_rd;
  logic [16:0] in_addr;
  logic        in_wait_n;
  logic        in_valid;
  logic [15:0] in_dout;
  logic        out_rd;
  logic [31:0] out_addr;
  logic        out_wait_n;
  logic        out_valid;
  logic [63:0] out_dout;

  modport slave (
    input  enable, invalidate, in_rd, in_addr, out_wait_n, out_valid, out_dout,
    output in_wait_n, in_valid, in_dout, out_rd, out_addr
  );

  modport master (
    output enable, invalidate, in_rd, in_addr, out_wait_n, out_valid, out_dout,
    input  in_wait_n, in_valid, in_dout, out_rd, out_addr
  );
endinterface

// File: rtl/ddr_word_reader.sv
// 16-bit word reads served from 64-bit DDR lines, up to DEPTH reads in flight, in-order responses.
// Optional one-line cache enabled by defining LINE_CACHE_EN.
module ddr_word_reader #(
  parameter int DEPTH = 4
) (
  input  logic            clock,
  input  logic            reset,
  ddr_word_reader_if.slave io
);
  localparam int PW = $clog2(DEPTH);

  typedef struct packed {
    logic [14:0] tag;
    logic [1:0]  lane;
  } pend_t;

  pend_t         pend_mem [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [PW:0]   count_reg;
  logic          in_valid_reg;
  logic [15:0]   in_dout_reg;

  logic          full;
  logic          empty;
  logic          hit;
  logic          accept_hit;
  logic          out_rd;
  logic          push;
  logic          pop;
  logic [15:0]   hit_word;
  pend_t         head;
  logic [15:0]   ddr_lane [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_ddr_lane
      assign ddr_lane[gi] = io.out_dout[gi*16 +: 16];
    end
  endgenerate

  assign full  = (count_reg == (PW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = pend_mem[rd_ptr_reg];

`ifdef LINE_CACHE_EN
  logic        cache_valid_reg;
  logic [14:0] cache_tag_reg;
  logic [63:0] cache_line_reg;
  logic [15:0] cache_lane [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cache_lane
      assign cache_lane[gi] = cache_line_reg[gi*16 +: 16];
    end
  endgenerate

  // An empty FIFO is required so a hit can never overtake an outstanding miss.
  assign hit      = cache_valid_reg & (cache_tag_reg == io.in_addr[16:2]) & empty & io.enable;
  assign hit_word = cache_lane[io.in_addr[1:0]];

  always_ff @(posedge clock) begin
    if (reset || io.invalidate || !io.enable) begin
      cache_valid_reg <= 1'b0;
    end else if (pop) begin
      cache_valid_reg <= 1'b1;
    end
    if (pop) begin
      cache_line_reg <= io.out_dout;
      cache_tag_reg  <= head.tag;
    end
  end
`else
  logic unused_cache_inputs;
  assign hit                 = 1'b0;
  assign hit_word            = '0;
  assign unused_cache_inputs = ^{io.invalidate, head.tag};
`endif

  assign out_rd     = ~reset & io.enable & io.in_rd & ~full & ~hit;
  assign accept_hit = ~reset & hit & io.in_rd;
  assign push       = out_rd & io.out_wait_n;
  // Data arriving with nothing pending (e.g. in flight across a reset) is dropped here.
  assign pop        = io.out_valid & ~empty;

  assign io.out_rd    = out_rd;
  assign io.out_addr  = {14'h0, io.in_addr[16:2], 3'b000};
  assign io.in_wait_n = ~reset & io.enable & ~full & (hit | io.out_wait_n);
  assign io.in_valid  = in_valid_reg;
  assign io.in_dout   = in_dout_reg;

  always_ff @(posedge clock) begin
    if (push) begin
      pend_mem[wr_ptr_reg] <= '{tag: io.in_addr[16:2], lane: io.in_addr[1:0]};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      in_valid_reg <= 1'b0;
      in_dout_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      count_reg    <= count_reg + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
      in_valid_reg <= pop | accept_hit;
      if (pop) begin
        in_dout_reg <= ddr_lane[head.lane];
      end else if (accept_hit) begin
        in_dout_reg <= hit_word;
      end
    end
  end
endmodule

// File: tb/tb_ddr_word_reader.sv
// Bench for ddr_word_reader: directed scenarios plus a random phase, checked against a DDR memory model.
// The LINE_CACHE_EN scenario is compiled in only when the macro is defined.
module tb_ddr_word_reader;
  logic clock = 1'b0;
  logic reset = 1'b1;

  ddr_word_reader_if bus ();

  ddr_word_reader #(.DEPTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [14:0] la;
    int          due;
  } ddr_req_t;

  int          vectors = 0;
  int          miscompares = 0;
  int          cyc = 0;
  int          resp_seen = 0;
  int          last_ov_cyc = -10;
  int          last_nodr_cyc = -10;
  int          last_due = 0;
  int          ddr_lat = 3;
  int          tmp_due;
  bit          ddr_hold = 1'b0;
  logic [15:0] exp_q [$];
  ddr_req_t    ddr_q [$];
  ddr_req_t    tmp_req;
  logic [15:0] tmp_word;

  // Backing memory: line 1 carries the reference pattern, other lines encode lane and line index.
  function automatic logic [63:0] mem_line(input logic [14:0] la);
    if (la == 15'd1) return 64'h4444_3333_2222_1111;
    return {4'hD, la[11:0], 4'hC, la[11:0], 4'hB, la[11:0], 4'hA, la[11:0]};
  endfunction

  function automatic logic [15:0] mem_word(input logic [16:0] a);
    logic [63:0] l;
    l = mem_line(a[16:2]);
    return l[16*a[1:0] +: 16];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Accepted requests and DDR handshakes, sampled just before the DUT updates.
  always @(posedge clock) begin
    cyc++;
    if (!reset) begin
      if (bus.out_valid) last_ov_cyc = cyc;
      if (bus.in_rd && bus.in_wait_n) begin
        exp_q.push_back(mem_word(bus.in_addr));
        if (!bus.out_rd) last_nodr_cyc = cyc;
      end
      if (bus.out_rd && bus.out_wait_n) begin
        check("out_addr", bus.out_addr, {14'h0, bus.in_addr[16:2], 3'b000});
        tmp_due = cyc + ddr_lat;
        if (tmp_due <= last_due) tmp_due = last_due + 1;
        last_due    = tmp_due;
        tmp_req.la  = bus.out_addr[17:3];
        tmp_req.due = tmp_due;
        ddr_q.push_back(tmp_req);
      end
    end
  end

  // DDR side: returns lines in order after the configured latency unless held.
  always @(negedge clock) begin
    bus.out_valid = 1'b0;
    if (!ddr_hold && ddr_q.size() > 0 && cyc >= ddr_q[0].due) begin
      bus.out_valid = 1'b1;
      bus.out_dout  = mem_line(ddr_q[0].la);
      void'(ddr_q.pop_front());
    end
  end

  // Every response must match the oldest accepted request, one cycle after its source event.
  always @(negedge clock) begin
    if (!reset && bus.in_valid) begin
      resp_seen++;
      if (exp_q.size() == 0) begin
        check("spurious_valid", bus.in_valid, 1'b0);
      end else begin
        tmp_word = exp_q.pop_front();
        check("rdata", bus.in_dout, tmp_word);
        check("latency", (last_ov_cyc == cyc) || (last_nodr_cyc == cyc), 1'b1);
      end
    end
  end

  task automatic drain(input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || ddr_q.size() > 0) && n < 100) begin
      @(negedge clock);
      n++;
    end
    repeat (2) @(negedge clock);
    check(tag, exp_q.size(), 0);
  endtask

  initial begin
    int r;
    int n;
    bus.enable     = 1'b1;
    bus.invalidate = 1'b0;
    bus.in_rd      = 1'b0;
    bus.in_addr    = '0;
    bus.out_wait_n = 1'b1;
    bus.out_valid  = 1'b0;
    bus.out_dout   = '0;

    // Reset state
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00005;
    #1;
    check("rst_out_rd", bus.out_rd, 1'b0);
    check("rst_wait_n", bus.in_wait_n, 1'b0);
    check("rst_valid", bus.in_valid, 1'b0);
    check("rst_dout", bus.in_dout, 16'h0);
    bus.in_rd = 1'b0;
    @(negedge clock);
    reset = 1'b0;

    // Single read, lane 1 of line 1
    ddr_lat = 3;
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00005;
    #1;
    check("t1_out_rd", bus.out_rd, 1'b1);
    check("t1_out_addr", bus.out_addr, 32'h0000_0008);
    check("t1_wait_n", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t1_drain");
    check("t1_dout", bus.in_dout, 16'h2222);
    check("t1_valid_low", bus.in_valid, 1'b0);

    // Fill all four slots with the DDR silent
    ddr_hold = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      bus.in_rd = 1'b1; bus.in_addr = 17'h00040 + 17'(i);
      #1;
      check("t2_accept", bus.in_wait_n, 1'b1);
    end
    @(negedge clock);
    bus.in_addr = 17'h00044;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t2_full_wait_n", bus.in_wait_n, 1'b0);
      check("t2_full_out_rd", bus.out_rd, 1'b0);
      @(negedge clock);
    end
    r = resp_seen;
    ddr_hold = 1'b0;
    #1;
    n = 0;
    while (!bus.in_wait_n && n < 50) begin
      @(negedge clock);
      #1;
      n++;
    end
    check("t2_unblock", bus.in_wait_n, 1'b1);
    check("t2_resp_at_unblock", resp_seen - r, 1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t2_drain");

    // DDR back-pressure
    r = resp_seen;
    bus.out_wait_n = 1'b0;
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00123;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("t3_stall_wait_n", bus.in_wait_n, 1'b0);
      check("t3_stall_out_rd", bus.out_rd, 1'b1);
      @(negedge clock);
    end
    bus.out_wait_n = 1'b1;
    #1;
    check("t3_accept", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t3_drain");
    check("t3_resp_count", resp_seen - r, 1);

    // Reset with two reads outstanding
    ddr_hold = 1'b1;
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00200;
    #1;
    check("t4_accept0", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_addr = 17'h00205;
    #1;
    check("t4_accept1", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    reset = 1'b1;
    exp_q.delete();
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    r = resp_seen;
    ddr_hold = 1'b0;
    repeat (10) @(negedge clock);
    check("t4_stale_delivered", ddr_q.size(), 0);
    check("t4_no_valid", resp_seen - r, 0);
    bus.in_rd = 1'b1; bus.in_addr = 17'h002A7;
    #1;
    check("t4_new_accept", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t4_drain");
    check("t4_new_dout", bus.in_dout, mem_word(17'h002A7));

`ifdef LINE_CACHE_EN
    // Line cache hit, then miss after invalidate
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00010;
    #1;
    check("t5_miss_out_rd", bus.out_rd, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t5_miss_drain");
    bus.in_rd = 1'b1; bus.in_addr = 17'h00013;
    #1;
    check("t5_hit_out_rd", bus.out_rd, 1'b0);
    check("t5_hit_wait_n", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    #1;
    check("t5_hit_valid", bus.in_valid, 1'b1);
    check("t5_hit_dout", bus.in_dout, mem_word(17'h00013));
    @(negedge clock);
    bus.invalidate = 1'b1;
    @(negedge clock);
    bus.invalidate = 1'b0;
    bus.in_rd = 1'b1; bus.in_addr = 17'h00013;
    #1;
    check("t5_inval_out_rd", bus.out_rd, 1'b1);
    @(negedge clock);
    bus.in_rd = 1'b0;
    drain("t5_inval_drain");
`endif

    // Disable with one read outstanding
    ddr_hold = 1'b1;
    @(negedge clock);
    bus.in_rd = 1'b1; bus.in_addr = 17'h00300;
    #1;
    check("t6_accept", bus.in_wait_n, 1'b1);
    @(negedge clock);
    bus.enable = 1'b0; bus.in_addr = 17'h00301;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t6_dis_wait_n", bus.in_wait_n, 1'b0);
      check("t6_dis_out_rd", bus.out_rd, 1'b0);
      @(negedge clock);
    end
    r = resp_seen;
    ddr_hold = 1'b0;
    n = 0;
    while (resp_seen == r && n < 50) begin
      @(negedge clock);
      n++;
    end
    check("t6_resp_while_disabled", resp_seen - r, 1);
    @(negedge clock);
    bus.enable = 1'b1; bus.in_rd = 1'b0;
    drain("t6_drain");

    // Random traffic over a small address window so lines repeat
    for (int i = 0; i < 600; i++) begin
      @(negedge clock);
      bus.in_rd      = ($urandom_range(0, 9) < 7);
      bus.in_addr    = 17'($urandom_range(0, 31));
      bus.out_wait_n = ($urandom_range(0, 3) != 0);
      bus.enable     = ($urandom_range(0, 19) != 0);
      bus.invalidate = ($urandom_range(0, 15) == 0);
      ddr_lat        = $urandom_range(1, 6);
    end
    @(negedge clock);
    bus.in_rd = 1'b0; bus.out_wait_n = 1'b1; bus.enable = 1'b1; bus.invalidate = 1'b0;
    drain("rnd_drain");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
